traffic_sensor_model: RTL and testbench
=======================================

Name: traffic_sensor_model

Overview:
- Synthesizable vehicle-queue model for the traffic_light_controller. It consumes the controller's light outputs and drives its sensor inputs.
- Each lane keeps a car count. Car-arrival pulses increment the count. Green time retires one car every DEPART_CYCLES cycles.
- Each sensor output is high while its lane's queue is non-empty.
- Sticky safety monitors flag conflicting greens/yellows, illegal light codes and queue overflow. This gives closed-loop stimulus and checking for controller regression runs.

Parameters:
- CNT_W, 4, width of each lane's car counter; the queue saturates at 2**CNT_W-1.
- DEPART_CYCLES, 2, consecutive green cycles needed to retire one car; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ew_left_arrive  in  1  one car arrives in the e-w left lane this cycle
- ew_str_arrive  in  1  one car arrives in the e-w straight lane this cycle
- ns_arrive  in  1  one car arrives in the n-s lane this cycle
- ew_left_light  in  2  controller output; 00 red, 01 yellow, 10 green, 11 illegal
- ew_str_light  in  2  same encoding
- ns_light  in  2  same encoding
- clr_flags  in  1  synchronous pulse; clears the sticky flags
- ew_left_sensor  out  1  ew_left_count != 0
- ew_str_sensor  out  1  ew_str_count != 0
- ns_sensor  out  1  ns_count != 0
- ew_left_count  out  CNT_W  cars queued in the e-w left lane
- ew_str_count  out  CNT_W  cars queued in the e-w straight lane
- ns_count  out  CNT_W  cars queued in the n-s lane
- served_total  out  16  total cars retired, all lanes, saturating
- overflow  out  1  sticky: an arrival was dropped because a queue was full
- conflict  out  1  sticky: two or more lights were non-red in the same cycle
- illegal  out  1  sticky: some light input was 11

Behaviour:
- Reset (async assert, sync release): all counts, timers, served_total and flags go to 0, so all sensors are 0.
- Per-lane departure timer (width 4):
  - Increments each cycle the lane is green and its count > 0.
  - When the timer == DEPART_CYCLES-1 on a green cycle with count > 0: one car departs, the timer returns to 0.
  - The timer clears whenever the light is not green or the count is 0. Red and yellow never retire cars.
- Per-lane count update at each clock edge:
  - arrive only: count+1, unless count is at max. At max the count holds and overflow is set.
  - depart only: count-1.
  - arrive and depart together: count unchanged. No overflow, even if the queue is full.
  - Count is never decremented below 0.
- Sensors are a combinational compare of the count registers. A sensor rises in the cycle after the arrival edge and falls in the cycle after the last departure edge.
- served_total adds the number of departures in the cycle (0..3) and saturates at 16'hFFFF.
- Conflict: set when more than one of the three lights is non-red (01 or 10) in a sampled cycle. All-red is legal.
- Illegal: set when any light input equals 11. A lane whose light is 11 is treated as red for departures.
- Flag priority: clr_flags clears all three flags at the next edge, but a new violation in the same cycle wins and the flag stays set. clr_flags does not affect counts or served_total.
- reset_n assertion mid-green: the queue empties immediately (asynchronously) and the timer clears. No partial credit to served_total.
- Lights are sampled only at clk edges. There is no internal knowledge of controller timing; the model is purely reactive.

Test Plan:
- Reset with 3 ew_str_arrive pulses already issued, then release -> all counts 0, sensors 0, flags 0, served_total 0.
- 3 ew_str_arrive pulses, then ew_str_light=10 held for 6 cycles (DEPART_CYCLES=2) -> ew_str_count 3,2,1,0 with a departure every 2 cycles; ew_str_sensor falls after the 6th green cycle; served_total=3.
- ns_count=2, ns_light green 1 cycle then yellow 4 cycles -> ns_count stays 2, timer cleared; a new green needs 2 full cycles before ns_count becomes 1.
- 16 ew_left_arrive pulses with CNT_W=4 -> ew_left_count saturates at 15, overflow=1. Then arrive plus departure in the same cycle -> count holds at 15 with no extra effect.
- ew_left_light=10 and ns_light=01 in the same cycle -> conflict=1. clr_flags with no violation -> conflict=0 next cycle. clr_flags in a cycle where ew_str_light=11 -> illegal=1 and remains 1.
- Closed loop with traffic_light_controller, ~1 arrival/lane every 20 cycles for 2000 cycles -> conflict=0, illegal=0, overflow=0, served_total equals total arrivals minus the sum of final counts.

Source files
------------

// File: rtl/traffic_sensor_model.sv
// traffic_sensor_model
// Reactive vehicle-queue model that sits around a traffic light controller.
// Each lane keeps a car queue. Arrivals push cars in, and green time retires
// one car every DEPART_CYCLES cycles. Sticky monitors watch the controller's
// light outputs for unsafe or malformed behaviour.
// Internal lane index: 0 = e-w left, 1 = e-w straight, 2 = n-s.

module traffic_sensor_model #(
    parameter int CNT_W         = 4,
    parameter int DEPART_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ew_left_arrive,
    input  logic             ew_str_arrive,
    input  logic             ns_arrive,
    input  logic [1:0]       ew_left_light,
    input  logic [1:0]       ew_str_light,
    input  logic [1:0]       ns_light,
    input  logic             clr_flags,
    output logic             ew_left_sensor,
    output logic             ew_str_sensor,
    output logic             ns_sensor,
    output logic [CNT_W-1:0] ew_left_count,
    output logic [CNT_W-1:0] ew_str_count,
    output logic [CNT_W-1:0] ns_count,
    output logic [15:0]      served_total,
    output logic             overflow,
    output logic             conflict,
    output logic             illegal
);

    localparam logic [1:0]       LIGHT_RED     = 2'b00;
    localparam logic [1:0]       LIGHT_GREEN   = 2'b10;
    localparam logic [1:0]       LIGHT_ILLEGAL = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;
    localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       TIMER_LAST    = 4'(DEPART_CYCLES - 1);

    logic [2:0][CNT_W-1:0] count_q;
    logic [2:0][CNT_W-1:0] count_d;
    logic [2:0][3:0]       timer_q;
    logic [2:0][3:0]       timer_d;
    logic [2:0][1:0]       light;
    logic [2:0]            arrive;
    logic [2:0]            depart;
    logic [2:0]            drop;
    logic [2:0]            non_red;
    logic [16:0]           served_sum;
    logic [15:0]           served_q;
    logic                  conflict_now;
    logic                  illegal_now;
    logic                  overflow_q;
    logic                  conflict_q;
    logic                  illegal_q;

    assign light  = {ns_light, ew_str_light, ew_left_light};
    assign arrive = {ns_arrive, ew_str_arrive, ew_left_arrive};

    // Per-lane departure timing and queue update; an illegal 11 code never matches green, so it acts as red
    always_comb begin
        count_d = count_q;
        timer_d = '0;
        depart  = '0;
        drop    = '0;
        for (int i = 0; i < 3; i++) begin
            if (light[i] == LIGHT_GREEN && count_q[i] != '0) begin
                if (timer_q[i] == TIMER_LAST) begin
                    depart[i]  = 1'b1;
                    timer_d[i] = 4'd0;
                end else begin
                    timer_d[i] = timer_q[i] + 4'd1;
                end
            end
            if (arrive[i] && !depart[i]) begin
                if (count_q[i] == CNT_MAX) begin
                    drop[i] = 1'b1;
                end else begin
                    count_d[i] = count_q[i] + CNT_ONE;
                end
            end else if (!arrive[i] && depart[i]) begin
                count_d[i] = count_q[i] - CNT_ONE;
            end
        end
    end

    // Safety checks on the sampled light codes; all-red is legal
    always_comb begin
        non_red      = '0;
        illegal_now  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            non_red[i] = (light[i] != LIGHT_RED) && (light[i] != LIGHT_ILLEGAL);
            if (light[i] == LIGHT_ILLEGAL) begin
                illegal_now = 1'b1;
            end
        end
        conflict_now = (non_red[0] & non_red[1]) | (non_red[0] & non_red[2]) |
                       (non_red[1] & non_red[2]);
    end

    // Served-car accumulator input, widened by one bit to detect saturation
    always_comb begin
        served_sum = {1'b0, served_q} + 17'(depart[0]) + 17'(depart[1]) + 17'(depart[2]);
    end

    // Queue counts and departure timers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            timer_q <= '0;
        end else begin
            count_q <= count_d;
            timer_q <= timer_d;
        end
    end

    // Saturating total of retired cars
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            served_q <= '0;
        end else if (served_sum[16]) begin
            served_q <= 16'hFFFF;
        end else begin
            served_q <= served_sum[15:0];
        end
    end

    // Sticky flags; a violation in the same cycle as clr_flags keeps the flag set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
            conflict_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            overflow_q <= (overflow_q & ~clr_flags) | (|drop);
            conflict_q <= (conflict_q & ~clr_flags) | conflict_now;
            illegal_q  <= (illegal_q  & ~clr_flags) | illegal_now;
        end
    end

    assign ew_left_count  = count_q[0];
    assign ew_str_count   = count_q[1];
    assign ns_count       = count_q[2];
    assign ew_left_sensor = (count_q[0] != '0);
    assign ew_str_sensor  = (count_q[1] != '0);
    assign ns_sensor      = (count_q[2] != '0);
    assign served_total   = served_q;
    assign overflow       = overflow_q;
    assign conflict       = conflict_q;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_traffic_sensor_model.sv
// tb_traffic_sensor_model
// Directed, table-driven bench for traffic_sensor_model with default
// parameters (CNT_W=4, DEPART_CYCLES=2), plus hand-written sequences for
// queue saturation and asynchronous reset in the middle of a green phase.

module tb_traffic_sensor_model;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic        clk;
    logic        reset_n;
    logic        ew_left_arrive;
    logic        ew_str_arrive;
    logic        ns_arrive;
    logic [1:0]  ew_left_light;
    logic [1:0]  ew_str_light;
    logic [1:0]  ns_light;
    logic        clr_flags;
    logic        ew_left_sensor;
    logic        ew_str_sensor;
    logic        ns_sensor;
    logic [3:0]  ew_left_count;
    logic [3:0]  ew_str_count;
    logic [3:0]  ns_count;
    logic [15:0] served_total;
    logic        overflow;
    logic        conflict;
    logic        illegal;

    int total_checks = 0;
    int bad_checks   = 0;

    // One cycle of stimulus and the state expected after the following rising edge
    typedef struct {
        string      name;
        logic [2:0] arr;
        logic [1:0] el;
        logic [1:0] es;
        logic [1:0] ns;
        logic       clr;
        int         e_el;
        int         e_es;
        int         e_ns;
        int         e_srv;
        int         e_ovf;
        int         e_cnf;
        int         e_ill;
    } vec_t;

    vec_t vecs[$];

    traffic_sensor_model dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ew_left_arrive (ew_left_arrive),
        .ew_str_arrive  (ew_str_arrive),
        .ns_arrive      (ns_arrive),
        .ew_left_light  (ew_left_light),
        .ew_str_light   (ew_str_light),
        .ns_light       (ns_light),
        .clr_flags      (clr_flags),
        .ew_left_sensor (ew_left_sensor),
        .ew_str_sensor  (ew_str_sensor),
        .ns_sensor      (ns_sensor),
        .ew_left_count  (ew_left_count),
        .ew_str_count   (ew_str_count),
        .ns_count       (ns_count),
        .served_total   (served_total),
        .overflow       (overflow),
        .conflict       (conflict),
        .illegal        (illegal)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total_checks++;
        if (act != exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int e_el, input int e_es, input int e_ns,
                               input int e_srv, input int e_ovf, input int e_cnf, input int e_ill);
        check({tag, " ew_left_count"}, int'(ew_left_count), e_el);
        check({tag, " ew_str_count"},  int'(ew_str_count),  e_es);
        check({tag, " ns_count"},      int'(ns_count),      e_ns);
        check({tag, " ew_left_sensor"}, int'(ew_left_sensor), int'(e_el != 0));
        check({tag, " ew_str_sensor"},  int'(ew_str_sensor),  int'(e_es != 0));
        check({tag, " ns_sensor"},      int'(ns_sensor),      int'(e_ns != 0));
        check({tag, " served_total"},  int'(served_total),  e_srv);
        check({tag, " overflow"},      int'(overflow),      e_ovf);
        check({tag, " conflict"},      int'(conflict),      e_cnf);
        check({tag, " illegal"},       int'(illegal),       e_ill);
    endtask

    task automatic applyStimulus(input logic [2:0] arr, input logic [1:0] el, input logic [1:0] es,
                                 input logic [1:0] ns, input logic clr);
        ew_left_arrive = arr[2];
        ew_str_arrive  = arr[1];
        ns_arrive      = arr[0];
        ew_left_light  = el;
        ew_str_light   = es;
        ns_light       = ns;
        clr_flags      = clr;
    endtask

    task automatic addVec(input string name, input logic [2:0] arr, input logic [1:0] el,
                          input logic [1:0] es, input logic [1:0] ns, input logic clr,
                          input int e_el, input int e_es, input int e_ns, input int e_srv,
                          input int e_ovf, input int e_cnf, input int e_ill);
        vec_t v;
        v.name = name; v.arr = arr; v.el = el; v.es = es; v.ns = ns; v.clr = clr;
        v.e_el = e_el; v.e_es = e_es; v.e_ns = e_ns; v.e_srv = e_srv;
        v.e_ovf = e_ovf; v.e_cnf = e_cnf; v.e_ill = e_ill;
        vecs.push_back(v);
    endtask

    initial begin
        // arrivals {el,es,ns}; lights el,es,ns; clr; expected el,es,ns,served,ovf,cnf,ill
        addVec("es_arr1",   3'b010, R, R, R, 0,  0, 1, 0, 0, 0, 0, 0);
        addVec("es_arr2",   3'b010, R, R, R, 0,  0, 2, 0, 0, 0, 0, 0);
        addVec("es_arr3",   3'b010, R, R, R, 0,  0, 3, 0, 0, 0, 0, 0);
        addVec("es_g1",     3'b000, R, G, R, 0,  0, 3, 0, 0, 0, 0, 0);
        addVec("es_g2",     3'b000, R, G, R, 0,  0, 2, 0, 1, 0, 0, 0);
        addVec("es_g3",     3'b000, R, G, R, 0,  0, 2, 0, 1, 0, 0, 0);
        addVec("es_g4",     3'b000, R, G, R, 0,  0, 1, 0, 2, 0, 0, 0);
        addVec("es_g5",     3'b000, R, G, R, 0,  0, 1, 0, 2, 0, 0, 0);
        addVec("es_g6",     3'b000, R, G, R, 0,  0, 0, 0, 3, 0, 0, 0);
        addVec("es_g_empty",3'b000, R, G, R, 0,  0, 0, 0, 3, 0, 0, 0);
        addVec("ns_arr1",   3'b001, R, R, R, 0,  0, 0, 1, 3, 0, 0, 0);
        addVec("ns_arr2",   3'b001, R, R, R, 0,  0, 0, 2, 3, 0, 0, 0);
        addVec("ns_g1",     3'b000, R, R, G, 0,  0, 0, 2, 3, 0, 0, 0);
        addVec("ns_y1",     3'b000, R, R, Y, 0,  0, 0, 2, 3, 0, 0, 0);
        addVec("ns_y2",     3'b000, R, R, Y, 0,  0, 0, 2, 3, 0, 0, 0);
        addVec("ns_y3",     3'b000, R, R, Y, 0,  0, 0, 2, 3, 0, 0, 0);
        addVec("ns_y4",     3'b000, R, R, Y, 0,  0, 0, 2, 3, 0, 0, 0);
        addVec("ns_regreen1",3'b000,R, R, G, 0,  0, 0, 2, 3, 0, 0, 0);
        addVec("ns_regreen2",3'b000,R, R, G, 0,  0, 0, 1, 4, 0, 0, 0);
        addVec("ns_red",    3'b000, R, R, R, 0,  0, 0, 1, 4, 0, 0, 0);
        addVec("conflict",  3'b000, G, R, Y, 0,  0, 0, 1, 4, 0, 1, 0);
        addVec("clr_cnf",   3'b000, R, R, R, 1,  0, 0, 1, 4, 0, 0, 0);
        addVec("clr_vs_ill",3'b000, R, X, R, 1,  0, 0, 1, 4, 0, 0, 1);
        addVec("ill_sticky",3'b000, R, R, R, 0,  0, 0, 1, 4, 0, 0, 1);
        addVec("clr_ill",   3'b000, R, R, R, 1,  0, 0, 1, 4, 0, 0, 0);
        addVec("es_arr_b",  3'b010, R, R, R, 0,  0, 1, 1, 4, 0, 0, 0);
        addVec("es_x1",     3'b000, R, X, R, 0,  0, 1, 1, 4, 0, 0, 1);
        addVec("es_x2",     3'b000, R, X, R, 0,  0, 1, 1, 4, 0, 0, 1);
        addVec("clr_ill2",  3'b000, R, R, R, 1,  0, 1, 1, 4, 0, 0, 0);
        addVec("dual_g1",   3'b000, R, G, G, 0,  0, 1, 1, 4, 0, 1, 0);
        addVec("dual_g2",   3'b000, R, G, G, 0,  0, 0, 0, 6, 0, 1, 0);
        addVec("clr_cnf2",  3'b000, R, R, R, 1,  0, 0, 0, 6, 0, 0, 0);

        // Reset held while ew_str arrivals are already being issued
        reset_n = 1'b0;
        applyStimulus(3'b000, R, R, R, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(3'b010, R, R, R, 1'b0);
        end
        @(negedge clk);
        applyStimulus(3'b000, R, R, R, 1'b0);
        reset_n = 1'b1;
        #1;
        checkOutput("reset", 0, 0, 0, 0, 0, 0, 0);

        // Table-driven vectors, one clock each
        foreach (vecs[k]) begin
            @(negedge clk);
            applyStimulus(vecs[k].arr, vecs[k].el, vecs[k].es, vecs[k].ns, vecs[k].clr);
            @(posedge clk);
            #1;
            checkOutput(vecs[k].name, vecs[k].e_el, vecs[k].e_es, vecs[k].e_ns, vecs[k].e_srv,
                        vecs[k].e_ovf, vecs[k].e_cnf, vecs[k].e_ill);
        end

        // Fill ew_left: 15 arrivals reach the limit without overflow
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(3'b100, R, R, R, 1'b0);
        end
        @(posedge clk);
        #1;
        checkOutput("fill15", 15, 0, 0, 6, 0, 0, 0);

        // 16th arrival is dropped
        @(negedge clk);
        applyStimulus(3'b100, R, R, R, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("fill16", 15, 0, 0, 6, 1, 0, 0);

        // Green without arrival primes the timer while overflow is cleared
        @(negedge clk);
        applyStimulus(3'b000, G, R, R, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("full_g1", 15, 0, 0, 6, 0, 0, 0);

        // Arrival and departure together on a full queue: count holds, no overflow
        @(negedge clk);
        applyStimulus(3'b100, G, R, R, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("full_arr_dep", 15, 0, 0, 7, 0, 0, 0);

        // Asynchronous reset mid-green empties queue and clears served_total at once
        @(negedge clk);
        applyStimulus(3'b000, G, R, R, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(3'b100, G, R, R, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("post_rst_arr", 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(3'b000, G, R, R, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("post_rst_g1", 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(3'b000, G, R, R, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("post_rst_g2", 0, 0, 0, 1, 0, 0, 0);

        @(negedge clk);
        applyStimulus(3'b000, R, R, R, 1'b0);
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
